// File: rtl/mem_access_stage_if.sv
// Memory-side bus of the MEM stage: request/ready handshake plus address and data.
//   mem_req   : access request, held for the whole access
//   mem_we    : 1 = store, 0 = load
//   mem_addr  : word-aligned byte address
//   mem_wdata : store data
//   mem_rdata : load data, valid while mem_ready is high
//   mem_ready : memory completes the access this cycle
// master = the pipeline stage, slave = the data memory.
interface mem_access_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ready
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage and MEM/WB register.
// Takes EX/MEM control, address and store data, performs loads/stores over a
// variable-latency req/ready memory bus, stalls upstream while an access is
// outstanding, and registers results towards WB.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   MemWriteIn/ReadIn   : store/load request from EX/MEM
//   MemToRegIn, RegWriteIn, ALUResultIn, WriteDataIn, DestinationRegIn : EX/MEM payload
//   memBus              : memory bus (master side)
//   stall               : holds PC, IF/ID, ID/EX, EX/MEM
//   mem_fault           : sticky misaligned-access or timeout flag
//   *Out                : registered MEM/WB outputs
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        MemWriteIn,
  input  logic                        MemReadIn,
  input  logic                        MemToRegIn,
  input  logic                        RegWriteIn,
  input  logic [31:0]                 ALUResultIn,
  input  logic [31:0]                 WriteDataIn,
  input  logic [4:0]                  DestinationRegIn,
  mem_access_stage_if.master          memBus,
  output logic                        stall,
  output logic                        mem_fault,
  output logic                        MemToRegOut,
  output logic                        RegWriteOut,
  output logic [31:0]                 ReadDataOut,
  output logic [31:0]                 ALUResultOut,
  output logic [4:0]                  DestinationRegOut
);

  localparam int unsigned CntWidth = $clog2(TIMEOUT + 1);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(TIMEOUT - 1);
  localparam logic [CntWidth-1:0] CntMax = {CntWidth{1'b1}};

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResume
  } state_e;

  state_e stateQ, stateD;
  logic [CntWidth-1:0] cntQ, cntD;

  // Hold registers for the instruction being accessed; holdAddr doubles as its ALU result.
  logic        holdWeQ, holdWeD;
  logic        holdMemToRegQ, holdMemToRegD;
  logic        holdRegWriteQ, holdRegWriteD;
  logic [31:0] holdAddrQ, holdAddrD;
  logic [31:0] holdWdataQ, holdWdataD;
  logic [4:0]  holdDestQ, holdDestD;

  logic        faultD;
  logic        memToRegD, regWriteD;
  logic [31:0] readDataD, aluResultD;
  logic [4:0]  destD;

  logic memOp;
  assign memOp = MemReadIn | MemWriteIn;

  always_comb begin
    stateD        = stateQ;
    cntD          = cntQ;
    holdWeD       = holdWeQ;
    holdMemToRegD = holdMemToRegQ;
    holdRegWriteD = holdRegWriteQ;
    holdAddrD     = holdAddrQ;
    holdWdataD    = holdWdataQ;
    holdDestD     = holdDestQ;
    faultD        = mem_fault;
    // MEM/WB outputs default to a bubble every cycle.
    memToRegD     = 1'b0;
    regWriteD     = 1'b0;
    readDataD     = 32'h0;
    aluResultD    = 32'h0;
    destD         = 5'h0;
    stall            = 1'b0;
    memBus.mem_req   = 1'b0;
    memBus.mem_we    = 1'b0;
    memBus.mem_addr  = 32'h0;
    memBus.mem_wdata = 32'h0;

    unique case (stateQ)
      StIdle: begin
        if (!memOp) begin
          memToRegD  = MemToRegIn;
          regWriteD  = RegWriteIn;
          aluResultD = ALUResultIn;
          destD      = DestinationRegIn;
        end else if (ALUResultIn[1:0] != 2'b00) begin
          // Misaligned: drop the instruction, flag it, no bus activity.
          faultD = 1'b1;
        end else begin
          stall         = 1'b1;
          holdWeD       = MemWriteIn;
          holdMemToRegD = MemToRegIn;
          holdRegWriteD = RegWriteIn;
          holdAddrD     = ALUResultIn;
          holdWdataD    = WriteDataIn;
          holdDestD     = DestinationRegIn;
          cntD          = '0;
          stateD        = StAccess;
        end
      end

      StAccess: begin
        stall            = 1'b1;
        memBus.mem_req   = 1'b1;
        memBus.mem_we    = holdWeQ;
        memBus.mem_addr  = holdAddrQ;
        memBus.mem_wdata = holdWdataQ;
        if (memBus.mem_ready) begin
          memToRegD  = holdMemToRegQ;
          regWriteD  = holdRegWriteQ;
          readDataD  = holdWeQ ? 32'h0 : memBus.mem_rdata;
          aluResultD = holdAddrQ;
          destD      = holdDestQ;
          stateD     = StResume;
        end else if (cntQ == CntLast) begin
          faultD = 1'b1;
          stateD = StResume;
        end else if (cntQ != CntMax) begin
          cntD = cntQ + CntWidth'(1);
        end
      end

      // EX/MEM still shows the completed instruction here; it is deliberately ignored.
      StResume: stateD = StIdle;

      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ            <= StIdle;
      cntQ              <= '0;
      holdWeQ           <= 1'b0;
      holdMemToRegQ     <= 1'b0;
      holdRegWriteQ     <= 1'b0;
      holdAddrQ         <= 32'h0;
      holdWdataQ        <= 32'h0;
      holdDestQ         <= 5'h0;
      mem_fault         <= 1'b0;
      MemToRegOut       <= 1'b0;
      RegWriteOut       <= 1'b0;
      ReadDataOut       <= 32'h0;
      ALUResultOut      <= 32'h0;
      DestinationRegOut <= 5'h0;
    end else begin
      stateQ            <= stateD;
      cntQ              <= cntD;
      holdWeQ           <= holdWeD;
      holdMemToRegQ     <= holdMemToRegD;
      holdRegWriteQ     <= holdRegWriteD;
      holdAddrQ         <= holdAddrD;
      holdWdataQ        <= holdWdataD;
      holdDestQ         <= holdDestD;
      mem_fault         <= faultD;
      MemToRegOut       <= memToRegD;
      RegWriteOut       <= regWriteD;
      ReadDataOut       <= readDataD;
      ALUResultOut      <= aluResultD;
      DestinationRegOut <= destD;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage. Each instruction task lays out the whole cycle-by-cycle
// timeline it must produce (stall window, bus window, result/bubble) into a queue;
// a compare process pops one expectation per cycle and checks the DUT at negedge.
module tb_mem_access_stage;
  localparam int unsigned TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemWriteIn, MemReadIn, MemToRegIn, RegWriteIn;
  logic [31:0] ALUResultIn, WriteDataIn;
  logic [4:0]  DestinationRegIn;
  logic        stall, mem_fault, MemToRegOut, RegWriteOut;
  logic [31:0] ReadDataOut, ALUResultOut;
  logic [4:0]  DestinationRegOut;

  mem_access_stage_if memBus ();

  mem_access_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk               (clk),
    .rst               (rst),
    .MemWriteIn        (MemWriteIn),
    .MemReadIn         (MemReadIn),
    .MemToRegIn        (MemToRegIn),
    .RegWriteIn        (RegWriteIn),
    .ALUResultIn       (ALUResultIn),
    .WriteDataIn       (WriteDataIn),
    .DestinationRegIn  (DestinationRegIn),
    .memBus            (memBus),
    .stall             (stall),
    .mem_fault         (mem_fault),
    .MemToRegOut       (MemToRegOut),
    .RegWriteOut       (RegWriteOut),
    .ReadDataOut       (ReadDataOut),
    .ALUResultOut      (ALUResultOut),
    .DestinationRegOut (DestinationRegOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall, req, we;
    logic [31:0] addr, wdata;
    logic        fault, m2r, rw;
    logic [31:0] rdata, alu;
    logic [4:0]  dest;
  } exp_t;

  exp_t expQ[$];
  exp_t cmpE;
  int checks = 0;
  int errors = 0;
  int stallCnt = 0;
  int reqCnt = 0;

  // Model of what is currently visible on the registered outputs.
  logic        curM2r, curRw, curFault;
  logic [31:0] curRdata, curAlu;
  logic [4:0]  curDest;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic bubble();
    curM2r = 1'b0; curRw = 1'b0; curRdata = 32'h0; curAlu = 32'h0; curDest = 5'h0;
  endtask

  task automatic pushExp(input logic st, input logic rq, input logic we,
                         input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    e.stall = st; e.req = rq; e.we = we; e.addr = a; e.wdata = wd;
    e.fault = curFault; e.m2r = curM2r; e.rw = curRw;
    e.rdata = curRdata; e.alu = curAlu; e.dest = curDest;
    expQ.push_back(e);
  endtask

  task automatic beginCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic r, input logic m2r, input logic rw,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] d);
    MemWriteIn = w; MemReadIn = r; MemToRegIn = m2r; RegWriteIn = rw;
    ALUResultIn = alu; WriteDataIn = wd; DestinationRegIn = d;
  endtask

  // Outside ACCESS the memory side is noise that must be ignored.
  task automatic idleMem();
    memBus.mem_ready = 1'($urandom_range(0, 1));
    memBus.mem_rdata = $urandom;
  endtask

  task automatic doAlu(input logic m2r, input logic rw, input logic [31:0] alu,
                       input logic [4:0] d);
    beginCycle();
    rst = 1'b0;
    drive(1'b0, 1'b0, m2r, rw, alu, 32'h0, d);
    idleMem();
    pushExp(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    curM2r = m2r; curRw = rw; curRdata = 32'h0; curAlu = alu; curDest = d;
  endtask

  // lat: ready arrives in the lat-th request cycle; 0 = never (timeout).
  // resetAt: request cycle during which rst is raised; -1 = none.
  task automatic doMem(input logic w, input logic r, input logic m2r, input logic rw,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd, input logic [4:0] d,
                       input int lat, input int resetAt);
    int n;
    beginCycle();
    rst = 1'b0;
    drive(w, r, m2r, rw, addr, wd, d);
    idleMem();
    if (addr[1:0] != 2'b00) begin
      pushExp(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      bubble();
      curFault = 1'b1;
      return;
    end
    pushExp(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    bubble();
    n = (lat == 0) ? int'(TIMEOUT) : lat;
    for (int i = 1; i <= n; i++) begin
      beginCycle();
      memBus.mem_ready = (i == lat);
      memBus.mem_rdata = (i == lat) ? rd : $urandom;
      if (i == resetAt) rst = 1'b1;
      pushExp(1'b1, 1'b1, w, addr, wd);
      if (i == resetAt) begin
        beginCycle();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'h0);
        idleMem();
        bubble();
        curFault = 1'b0;
        pushExp(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        return;
      end
    end
    if (lat != 0) begin
      curM2r = m2r; curRw = rw; curRdata = w ? 32'h0 : rd; curAlu = addr; curDest = d;
    end else begin
      bubble();
      curFault = 1'b1;
    end
    // RESUME: inputs still show the instruction, memory noise is ignored.
    beginCycle();
    memBus.mem_ready = 1'b1;
    memBus.mem_rdata = $urandom;
    pushExp(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    bubble();
  endtask

  // Compare process.
  initial begin
    forever begin
      @(negedge clk);
      if (stall === 1'b1) stallCnt++;
      if (memBus.mem_req === 1'b1) reqCnt++;
      if (expQ.size() > 0) begin
        cmpE = expQ.pop_front();
        chk("stall", 32'(stall), 32'(cmpE.stall));
        chk("mem_req", 32'(memBus.mem_req), 32'(cmpE.req));
        chk("mem_we", 32'(memBus.mem_we), 32'(cmpE.we));
        chk("mem_addr", memBus.mem_addr, cmpE.addr);
        chk("mem_wdata", memBus.mem_wdata, cmpE.wdata);
        chk("mem_fault", 32'(mem_fault), 32'(cmpE.fault));
        chk("MemToRegOut", 32'(MemToRegOut), 32'(cmpE.m2r));
        chk("RegWriteOut", 32'(RegWriteOut), 32'(cmpE.rw));
        chk("ReadDataOut", ReadDataOut, cmpE.rdata);
        chk("ALUResultOut", ALUResultOut, cmpE.alu);
        chk("DestinationRegOut", 32'(DestinationRegOut), 32'(cmpE.dest));
      end
    end
  end

  // Driver with hand-computed literal checks.
  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'h0);
    memBus.mem_ready = 1'b0;
    memBus.mem_rdata = 32'h0;
    bubble();
    curFault = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    pushExp(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // ALU op passes straight through.
    doAlu(1'b0, 1'b1, 32'h0000_1234, 5'd5);
    doAlu(1'b0, 1'b0, 32'h0, 5'd0);
    #2;
    chk("alu_regwrite", 32'(RegWriteOut), 32'd1);
    chk("alu_result", ALUResultOut, 32'h0000_1234);
    chk("alu_dest", 32'(DestinationRegOut), 32'd5);

    // Load, ready on the 4th request cycle (same cycle the timeout would fire).
    stallCnt = 0; reqCnt = 0;
    doMem(1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 32'h0, 32'hDEAD_BEEF, 5'd7, 4, -1);
    chk("load_stall_cycles", 32'(stallCnt), 32'd5);
    chk("load_req_cycles", 32'(reqCnt), 32'd4);
    #2;
    chk("load_rdata", ReadDataOut, 32'hDEAD_BEEF);
    chk("load_memtoreg", 32'(MemToRegOut), 32'd1);
    chk("load_no_fault", 32'(mem_fault), 32'd0);
    doAlu(1'b0, 1'b0, 32'h0, 5'd0);
    #2;
    chk("load_then_bubble", ReadDataOut, 32'h0);

    // Store, ready immediately.
    stallCnt = 0; reqCnt = 0;
    doMem(1'b1, 1'b0, 1'b0, 1'b0, 32'h80, 32'hCAFE_F00D, 32'h0, 5'd0, 1, -1);
    chk("store_req_cycles", 32'(reqCnt), 32'd1);
    chk("store_stall_cycles", 32'(stallCnt), 32'd2);
    #2;
    chk("store_regwrite", 32'(RegWriteOut), 32'd0);

    // Read and write both set: behaves as a store.
    doMem(1'b1, 1'b1, 1'b0, 1'b0, 32'h84, 32'h1111_2222, 32'h9999_9999, 5'd2, 2, -1);
    #2;
    chk("rw_both_rdata", ReadDataOut, 32'h0);

    // Misaligned load is dropped and flagged.
    stallCnt = 0; reqCnt = 0;
    doMem(1'b0, 1'b1, 1'b1, 1'b1, 32'h41, 32'h0, 32'h1, 5'd4, 3, -1);
    doAlu(1'b0, 1'b1, 32'h0000_0055, 5'd6);
    #2;
    chk("misalign_fault", 32'(mem_fault), 32'd1);
    chk("misalign_regwrite", 32'(RegWriteOut), 32'd0);
    chk("misalign_no_req", 32'(reqCnt), 32'd0);
    chk("misalign_no_stall", 32'(stallCnt), 32'd0);

    // Timeout: ready never comes.
    reqCnt = 0;
    doMem(1'b0, 1'b1, 1'b1, 1'b1, 32'h100, 32'h0, 32'h0, 5'd9, 0, -1);
    chk("timeout_req_cycles", 32'(reqCnt), 32'(TIMEOUT));
    #2;
    chk("timeout_fault_sticky", 32'(mem_fault), 32'd1);
    chk("timeout_bubble", 32'(RegWriteOut), 32'd0);

    // Reset in the 2nd request cycle, then a normal load.
    doMem(1'b0, 1'b1, 1'b1, 1'b1, 32'hC0, 32'h0, 32'h1234_5678, 5'd8, 3, 2);
    #2;
    chk("rst_req", 32'(memBus.mem_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_fault", 32'(mem_fault), 32'd0);
    chk("rst_alu", ALUResultOut, 32'h0);
    doMem(1'b0, 1'b1, 1'b1, 1'b1, 32'hC4, 32'h0, 32'h55AA_55AA, 5'd3, 2, -1);
    #2;
    chk("post_rst_rdata", ReadDataOut, 32'h55AA_55AA);
    chk("post_rst_dest", 32'(DestinationRegOut), 32'd3);

    doAlu(1'b1, 1'b1, 32'h0000_0ABC, 5'd31);
    doAlu(1'b0, 1'b0, 32'h0, 5'd0);
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
MEM pipeline stage, directly downstream of the EX/MEM register. It consumes EX/MEM control, address and store data, and runs loads and stores against a data memory with variable latency over a req/ready handshake. It stalls the upstream pipeline while an access is outstanding. It registers its results into MEM/WB-facing outputs, so it also acts as the MEM/WB register.

Parameters:
TIMEOUT, 15, max ACCESS cycles without mem_ready before abort (>=1); counter width = clog2(TIMEOUT+1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
MemWriteIn  in  1  store request from EX/MEM
MemReadIn  in  1  load request from EX/MEM
MemToRegIn  in  1  WB select from EX/MEM
RegWriteIn  in  1  register write enable from EX/MEM
ALUResultIn  in  32  effective address / ALU result
WriteDataIn  in  32  store data
DestinationRegIn  in  5  destination register
mem_rdata  in  32  memory read data, valid with mem_ready
mem_ready  in  1  memory completes access this cycle
mem_req  out  1  access request
mem_we  out  1  1=store, 0=load
mem_addr  out  32  word address (byte address, [1:0]=0)
mem_wdata  out  32  store data
stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM (drives their en low)
mem_fault  out  1  sticky: misaligned access or timeout
MemToRegOut  out  1  to WB
RegWriteOut  out  1  to WB
ReadDataOut  out  32  load data to WB
ALUResultOut  out  32  ALU result to WB
DestinationRegOut  out  5  to WB

Behaviour:
- Clock and reset: single clock clk, rising edge; rst is synchronous and active-high.
- Reset values: state=IDLE, timeout counter=0, hold registers=0, all outputs=0, mem_fault=0. Reset during ACCESS abandons the access; mem_req is 0 from the next cycle.
- FSM states: IDLE, ACCESS, RESUME.
- IDLE, no memory op (MemReadIn=MemWriteIn=0):
  - stall=0.
  - Next edge: MemToRegOut, RegWriteOut, ALUResultOut, DestinationRegOut <= inputs; ReadDataOut <= 0.
  - Latency 1 cycle.
- IDLE, memory op, ALUResultIn[1:0]!=0 (misaligned):
  - No access; stall=0.
  - Next edge: mem_fault<=1; outputs <= bubble (RegWriteOut=0, MemToRegOut=0, data/dest 0).
  - The instruction is dropped.
- IDLE, memory op, aligned:
  - stall=1 combinationally.
  - Next edge: latch address, store data, we (=MemWriteIn; write wins if both set), MemToRegIn, RegWriteIn, dest and ALUResult into hold registers.
  - Counter<=0; state->ACCESS; MEM/WB outputs <= bubble.
- ACCESS:
  - mem_req=1; mem_we/mem_addr/mem_wdata driven from hold registers, stable for the whole state; stall=1.
  - Each edge with mem_ready=0: counter+1.
  - Edge with mem_ready=1: outputs <= hold control/dest/ALUResult; ReadDataOut <= mem_rdata for a load, 0 for a store; state->RESUME.
  - Edge with mem_ready=0 and counter==TIMEOUT-1: mem_fault<=1; outputs <= bubble; state->RESUME.
  - mem_ready wins over timeout in the same cycle.
- RESUME:
  - stall=0, mem_req=0.
  - The EX/MEM inputs still show the just-completed instruction; they are ignored and not reissued.
  - Next edge: outputs <= bubble; state->IDLE.
  - Back-to-back memory ops therefore cost the access latency plus 2 cycles each.
- Outside ACCESS: mem_ready and mem_rdata are ignored; mem_req, mem_we, mem_addr, mem_wdata = 0.
- mem_fault is sticky until rst.
- No arithmetic beyond the counter; the counter saturates, and TIMEOUT bounds its use.

Test Plan:
- ALU op (RegWriteIn=1, ALUResultIn=0x1234, dest=5) in IDLE -> next cycle RegWriteOut=1, ALUResultOut=0x1234, DestinationRegOut=5, stall=0 throughout.
- Load from 0x40, mem_ready 3 cycles after mem_req, mem_rdata=0xDEADBEEF -> stall high 5 cycles, mem_addr=0x40, mem_we=0, then ReadDataOut=0xDEADBEEF with MemToRegOut=1 for exactly 1 cycle, then bubble.
- Store to 0x80 of 0xCAFEF00D, mem_ready same cycle as mem_req -> mem_we=1, mem_wdata=0xCAFEF00D held 1 cycle, RegWriteOut=0, stall released after RESUME.
- Load from 0x41 -> no mem_req, mem_fault=1 next cycle and stays 1, RegWriteOut=0, stall=0.
- TIMEOUT=4, mem_ready never asserted -> mem_req high exactly 4 cycles, mem_fault=1, bubble output, state returns to IDLE.
- rst asserted in 2nd ACCESS cycle -> next cycle mem_req=0, stall=0, all outputs 0; a subsequent load completes normally.
